// File: rtl/ldpc_wb_master.sv
// rtl/ldpc_wb_master.sv - Wishbone classic master issuing sequential single-word read/write bursts
//
// Optional feature macro: WBM_TIMEOUT_EN (abort a transfer after TIMEOUT stb cycles without ack)
//
// Parameters:
//   LEN_W   - burst length field width; burst = cmd_len + 1 words
//   TIMEOUT - stb cycles allowed without ack (WBM_TIMEOUT_EN builds only)
//
// Ports:
//   wb_clk_i, wb_rst_i                 clock, synchronous active-high reset
//   cmd_valid/cmd_ready, cmd_we,
//   cmd_adr, cmd_len                   burst command handshake
//   wr_valid/wr_ready, wr_data         write word stream (one word per write transfer)
//   rd_valid, rd_data                  read word pulse, no backpressure
//   busy, done, err                    burst status; err qualified by done
//   wbm_*                              Wishbone classic master port
module ldpc_wb_master #(
    parameter int LEN_W   = 8,
    parameter int TIMEOUT = 255
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_we,
    input  logic [31:0]      cmd_adr,
    input  logic [LEN_W-1:0] cmd_len,
    input  logic             wr_valid,
    output logic             wr_ready,
    input  logic [31:0]      wr_data,
    output logic             rd_valid,
    output logic [31:0]      rd_data,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic             wbm_cyc_o,
    output logic             wbm_stb_o,
    output logic             wbm_we_o,
    output logic [3:0]       wbm_sel_o,
    output logic [31:0]      wbm_adr_o,
    output logic [31:0]      wbm_dat_o,
    input  logic             wbm_ack_i,
    input  logic [31:0]      wbm_dat_i
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_REQ   = 3'd2,
        S_GAP   = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("ldpc_wb_master: TIMEOUT must be at least 1");
    end

    state_t             state;
    state_t             state_nxt;
    logic               we_r;
    logic [31:0]        adr_r;
    logic [31:0]        dat_r;
    logic [LEN_W-1:0]   rem_r;
    logic               accept;
    logic               xfer;
    logic               last_word;
    logic               timeout_hit;
    logic               err_r;

    assign accept    = (state == S_IDLE) && cmd_valid;
    // An ack only completes a transfer while stb is up; acks in FETCH/GAP are ignored.
    assign xfer      = (state == S_REQ) && wbm_ack_i;
    assign last_word = (rem_r == '0);

`ifdef WBM_TIMEOUT_EN
    localparam int TCNT_W = $clog2(TIMEOUT + 1);

    logic [TCNT_W-1:0] tcnt;

    // Counter is held at zero outside REQ, so it restarts on every REQ entry.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i || state != S_REQ) begin
            tcnt <= '0;
        end else if (!wbm_ack_i) begin
            tcnt <= tcnt + 1'b1;
        end
    end

    assign timeout_hit = (state == S_REQ) && !wbm_ack_i && (tcnt == TCNT_W'(TIMEOUT - 1));

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i || accept) begin
            err_r <= 1'b0;
        end else if (timeout_hit) begin
            err_r <= 1'b1;
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign err_r       = 1'b0;
`endif

    // State register
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (cmd_valid) state_nxt = cmd_we ? S_FETCH : S_REQ;
            S_FETCH: if (wr_valid) state_nxt = S_REQ;
            S_REQ: begin
                if (wbm_ack_i) begin
                    if (last_word) state_nxt = S_DONE;
                    else           state_nxt = we_r ? S_FETCH : S_GAP;
                end else if (timeout_hit) begin
                    state_nxt = S_DONE;
                end
            end
            S_GAP:   state_nxt = S_REQ;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Outputs decoded from state so that reset drops cyc/stb on the very next edge.
    always_comb begin
        cmd_ready = 1'b0;
        wr_ready  = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        err       = 1'b0;
        wbm_cyc_o = 1'b0;
        wbm_stb_o = 1'b0;
        wbm_sel_o = 4'h0;
        case (state)
            S_IDLE:  cmd_ready = !wb_rst_i;
            S_FETCH: begin
                wr_ready  = 1'b1;
                busy      = 1'b1;
                wbm_cyc_o = 1'b1;
            end
            S_REQ: begin
                busy      = 1'b1;
                wbm_cyc_o = 1'b1;
                wbm_stb_o = 1'b1;
                wbm_sel_o = 4'hF;
            end
            S_GAP: begin
                busy      = 1'b1;
                wbm_cyc_o = 1'b1;
            end
            S_DONE: begin
                done = 1'b1;
                err  = err_r;
            end
            default: ;
        endcase
    end

    assign wbm_we_o  = we_r;
    assign wbm_adr_o = adr_r;
    assign wbm_dat_o = dat_r;

    // Burst datapath: address/data only move outside stb so they stay stable while stb is high.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            we_r     <= 1'b0;
            adr_r    <= '0;
            dat_r    <= '0;
            rem_r    <= '0;
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= 1'b0;
            if (accept) begin
                we_r  <= cmd_we;
                adr_r <= cmd_adr;
                rem_r <= cmd_len;
            end
            if (state == S_FETCH && wr_valid) begin
                dat_r <= wr_data;
            end
            if (xfer) begin
                adr_r <= adr_r + 32'd4;
                rem_r <= rem_r - 1'b1;
                if (!we_r) begin
                    rd_data  <= wbm_dat_i;
                    rd_valid <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_ldpc_wb_master.sv
// tb/tb_ldpc_wb_master.sv - scoreboard bench for ldpc_wb_master
module tb_ldpc_wb_master;

    localparam int LEN_W = 8;
    localparam logic [31:0] RD_KEY = 32'hA5A5_A5A5;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             cmd_valid = 1'b0;
    logic             cmd_ready;
    logic             cmd_we = 1'b0;
    logic [31:0]      cmd_adr = '0;
    logic [LEN_W-1:0] cmd_len = '0;
    logic             wr_valid = 1'b0;
    logic             wr_ready;
    logic [31:0]      wr_data = '0;
    logic             rd_valid;
    logic [31:0]      rd_data;
    logic             busy, done, err;
    logic             cyc, stb, we;
    logic [3:0]       sel;
    logic [31:0]      adr, dat_o;
    logic             ack;
    logic [31:0]      dat_i;

    int               waits  = 0;
    logic             no_ack = 1'b0;
    logic             spur   = 1'b0;
    int               wcnt   = 0;

    int               n_cmp = 0;
    int               n_bad = 0;
    int               xfer_cnt = 0;

    logic [31:0]      exp_adr[$];
    logic [31:0]      exp_rd[$];
    logic [31:0]      exp_wd[$];

    always #5 clk = ~clk;

    ldpc_wb_master #(.LEN_W(LEN_W), .TIMEOUT(4)) dut (
        .wb_clk_i (clk),       .wb_rst_i (rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_we   (cmd_we),    .cmd_adr  (cmd_adr),   .cmd_len(cmd_len),
        .wr_valid (wr_valid),  .wr_ready (wr_ready),  .wr_data(wr_data),
        .rd_valid (rd_valid),  .rd_data  (rd_data),
        .busy     (busy),      .done     (done),      .err    (err),
        .wbm_cyc_o(cyc),       .wbm_stb_o(stb),       .wbm_we_o(we),
        .wbm_sel_o(sel),       .wbm_adr_o(adr),       .wbm_dat_o(dat_o),
        .wbm_ack_i(ack),       .wbm_dat_i(dat_i)
    );

    // Slave model: combinational ack after `waits` stb cycles; read data keyed on address.
    always @(posedge clk) wcnt <= (stb && !ack) ? wcnt + 1 : 0;
    assign ack   = (stb && !no_ack && (wcnt >= waits)) || spur;
    assign dat_i = adr ^ RD_KEY;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Monitor: pop expectations as transfers complete and read words come back.
    always @(negedge clk) begin
        if (stb && ack) begin
            xfer_cnt++;
            check("sel", {28'd0, sel}, 32'hF);
            if (exp_adr.size() == 0) check("unexpected_xfer", 32'd1, 32'd0);
            else check("adr", adr, exp_adr.pop_front());
            if (we) begin
                if (exp_wd.size() == 0) check("unexpected_wr", 32'd1, 32'd0);
                else check("wr_dat", dat_o, exp_wd.pop_front());
            end
        end
        if (rd_valid) begin
            if (exp_rd.size() == 0) check("unexpected_rd", 32'd1, 32'd0);
            else check("rd_data", rd_data, exp_rd.pop_front());
        end
    end

    task automatic issue(input logic w, input logic [31:0] a, input logic [LEN_W-1:0] len);
        @(negedge clk);
        check("cmd_ready_pre", {31'd0, cmd_ready}, 32'd1);
        for (int i = 0; i <= int'(len); i++) begin
            exp_adr.push_back(a + 32'(4 * i));
            if (!w) exp_rd.push_back((a + 32'(4 * i)) ^ RD_KEY);
        end
        xfer_cnt  = 0;
        cmd_valid = 1'b1; cmd_we = w; cmd_adr = a; cmd_len = len;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic feed(input int n, input int delay, input logic [31:0] base);
        for (int i = 0; i < n; i++) begin
            int t = 0;
            @(negedge clk);
            while (!wr_ready && t < 100) begin @(negedge clk); t++; end
            check("wr_ready_seen", {31'd0, wr_ready}, 32'd1);
            for (int d = 0; d < delay; d++) begin
                check("wait_cyc", {31'd0, cyc}, 32'd1);
                check("wait_stb", {31'd0, stb}, 32'd0);
                @(negedge clk);
            end
            wr_valid = 1'b1; wr_data = base + 32'(i);
            exp_wd.push_back(base + 32'(i));
            @(posedge clk); #1;
            wr_valid = 1'b0;
            @(negedge clk);
            check("stb_after_wr", {31'd0, stb}, 32'd1);
        end
    endtask

    task automatic wait_done(input logic exp_err);
        int t = 0;
        @(negedge clk);
        while (!done && t < 300) begin @(negedge clk); t++; end
        check("done_seen", {31'd0, done}, 32'd1);
        check("err", {31'd0, err}, {31'd0, exp_err});
        check("cyc_at_done", {31'd0, cyc}, 32'd0);
        @(negedge clk);
        check("cmd_ready_post", {31'd0, cmd_ready}, 32'd1);
        check("busy_post", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        check("rst_outs", {cmd_ready, wr_ready, rd_valid, busy, done, err, cyc, stb, we, sel}, 32'd0);
        check("rst_adr", adr, 32'd0);
        check("rst_dat", dat_o, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("cmd_ready_rst", {31'd0, cmd_ready}, 32'd1);

        // Zero-wait read burst with cycle-exact latency
        issue(1'b0, 32'h3000_0000, 8'd3);
        @(negedge clk);
        check("c1_stb", {30'd0, stb, cyc}, 32'd3);
        check("c1_busy", {31'd0, busy}, 32'd1);
        @(negedge clk);
        check("c2_rdv", {30'd0, rd_valid, stb}, 32'd2);
        @(negedge clk);
        check("c3_stb", {31'd0, stb}, 32'd1);
        wait_done(1'b0);
        check("rd_xfers", xfer_cnt, 32'd4);

        // Write burst with delayed write data
        issue(1'b1, 32'h0000_1000, 8'd1);
        feed(2, 5, 32'hDEAD_0001);
        wait_done(1'b0);
        check("wr_xfers", xfer_cnt, 32'd2);

        // Address wrap
        issue(1'b0, 32'hFFFF_FFF8, 8'd2);
        wait_done(1'b0);
        check("wrap_xfers", xfer_cnt, 32'd3);

        // Wait states plus a spurious ack during GAP
        waits = 3;
        issue(1'b0, 32'h0000_0100, 8'd3);
        begin
            int t = 0;
            @(negedge clk);
            while (!(stb && ack) && t < 50) begin @(negedge clk); t++; end
        end
        @(posedge clk); #1;
        check("gap_stb", {31'd0, stb}, 32'd0);
        spur = 1'b1;
        @(posedge clk); #1;
        spur = 1'b0;
        wait_done(1'b0);
        check("ws_xfers", xfer_cnt, 32'd4);
        waits = 0;

        // Slave never acks
        no_ack = 1'b1;
        issue(1'b0, 32'h0000_0200, 8'd3);
`ifdef WBM_TIMEOUT_EN
        begin
            int n_stb = 0;
            int t = 0;
            @(negedge clk);
            while (!done && t < 50) begin
                if (stb) n_stb++;
                @(negedge clk); t++;
            end
            check("to_stb_cycles", n_stb, 32'd4);
            check("to_done", {31'd0, done}, 32'd1);
            check("to_err", {31'd0, err}, 32'd1);
            check("to_cyc", {31'd0, cyc}, 32'd0);
        end
`else
        begin
            int n_stb = 0;
            for (int i = 0; i < 20; i++) begin
                @(negedge clk);
                if (stb && !done) n_stb++;
            end
            check("noto_stb_cycles", n_stb, 32'd20);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
`endif
        no_ack = 1'b0;
        exp_adr.delete();
        exp_rd.delete();
        @(negedge clk);
        check("noack_idle", {31'd0, cmd_ready}, 32'd1);

        // Reset mid-burst
        waits = 2;
        issue(1'b0, 32'h0000_0400, 8'd7);
        repeat (6) @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        check("mid_rst_ctl", {29'd0, cyc, stb, busy}, 32'd0);
        begin
            logic seen = 1'b0;
            for (int i = 0; i < 3; i++) begin
                @(negedge clk);
                if (done) seen = 1'b1;
            end
            check("mid_rst_no_done", {31'd0, seen}, 32'd0);
        end
        rst = 1'b0;
        exp_adr.delete();
        exp_rd.delete();
        @(negedge clk);
        check("mid_rst_ready", {31'd0, cmd_ready}, 32'd1);
        waits = 0;

        // Recovery burst after reset
        issue(1'b0, 32'h0000_0800, 8'd1);
        wait_done(1'b0);
        check("rec_xfers", xfer_cnt, 32'd2);
        check("sb_empty", exp_adr.size() + exp_rd.size() + exp_wd.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ldpc_wb_master.md
# ldpc_wb_master

Wishbone classic bus master that drives the LDPC encoder/decoder's Wishbone slave port from a simple command/stream interface. It issues bursts of sequential single-word read or write cycles: codeword loads, syndrome/result readback and register access. It is used by the on-chip bring-up sequencer and in block-level benches to exercise the slave end of the interface. All logic runs on the Wishbone clock.

## Interface
Parameters:
- LEN_W, 8, width of burst-length field; burst length = cmd_len + 1 words (1..2^LEN_W)
- TIMEOUT, 255, max cycles stb may wait for ack (used only with WBM_TIMEOUT_EN)

Ports:
- wb_clk_i  in  1  clock; single clock domain
- wb_rst_i  in  1  synchronous, active-high reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready
- cmd_we  in  1  1 = write burst, 0 = read burst
- cmd_adr  in  32  start byte address, word aligned
- cmd_len  in  LEN_W  words minus one
- wr_valid  in  1  write data available
- wr_ready  out  1  write word consumed when wr_valid & wr_ready
- wr_data  in  32  write word
- rd_valid  out  1  one-cycle pulse, rd_data valid; no backpressure
- rd_data  out  32  read word
- busy  out  1  burst in progress
- done  out  1  one-cycle pulse at burst end
- err  out  1  qualified by done; 1 = aborted by timeout
- wbm_cyc_o, wbm_stb_o, wbm_we_o  out  1  Wishbone master controls
- wbm_sel_o  out  4  byte selects, always 4'hF during stb
- wbm_adr_o  out  32  address
- wbm_dat_o  out  32  write data
- wbm_ack_i  in  1  slave acknowledge
- wbm_dat_i  in  32  slave read data

## Operation
- States: IDLE, FETCH, REQ, GAP, DONE.
- IDLE: cmd_ready=1. On accept, latch we/adr/len, set busy and cyc. Next state is FETCH when cmd_we=1, else REQ.
- FETCH: wr_ready=1, stb=0. On wr_valid, latch wr_data into wbm_dat_o and go to REQ.
- REQ: stb=1, we=latched cmd_we, sel=4'hF. On ack:
  - Read: capture wbm_dat_i; rd_valid pulses next cycle.
  - Address advances by 4, modulo 2^32; wrap from 32'hFFFF_FFFC to 0 is legal.
  - Remaining-count decrements. If this was the last word go to DONE; else write → FETCH, read → GAP.
- GAP: stb=0 for one cycle, cyc held, then REQ.
- DONE: cyc=stb=0, busy=0, done=1 for one cycle, then IDLE.
- cyc stays high for the whole burst, including FETCH waits.
- wbm_ack_i while stb=0 is ignored.
- cmd_valid while busy is not accepted.
- Reset mid-burst: all state cleared on the next edge; no done pulse; cyc/stb drop immediately.

## Timing
- Reset values: every output 0, except cmd_ready=1 after reset completes. Addr/data regs are 0.
- Read, zero-wait slave (ack combinational with stb): cmd accepted at cycle 0; stb high in cycle 1; rd_valid in cycle 2; next stb in cycle 3. Steady state is 2 cycles/word.
- Write: stb rises the cycle after the wr_valid&wr_ready handshake; minimum 2 cycles/word.
- done rises the cycle after the final ack. cmd_ready returns the cycle after done.
- wbm_adr_o/wbm_dat_o/wbm_we_o are stable for the whole time stb is high.

## Configuration
- WBM_TIMEOUT_EN defined: a counter clears on each REQ entry and counts REQ cycles without ack.
  - Ack in any of the first TIMEOUT stb cycles is accepted normally.
  - With no ack after TIMEOUT cycles, the next state is DONE with err=1. Remaining words are abandoned and no further wr_ready is given.
- Not defined: no counter; REQ waits indefinitely; err tied to 0.

## Test plan
- Read burst cmd_adr=32'h3000_0000, cmd_len=3, zero-wait slave returning adr^32'hA5A5A5A5 → 4 rd_valid pulses with matching data; addresses 0x3000_0000..0x3000_000C; done=1, err=0.
- Write burst cmd_len=1, wr_valid delayed 5 cycles → cyc held high, stb low during the wait; dat_o=wr_data while stb high; two acks; done.
- Address wrap: cmd_adr=32'hFFFF_FFF8, cmd_len=2, read → addresses FFFF_FFF8, FFFF_FFFC, 0000_0000.
- Slave with 3 wait states plus a spurious ack while stb=0 → spurious ack ignored; exactly cmd_len+1 transfers.
- WBM_TIMEOUT_EN, TIMEOUT=4, slave never acks → stb high exactly 4 cycles, then done=1, err=1, cyc=0. Without the macro, stb stays high indefinitely.
- wb_rst_i asserted mid-burst → next cycle cyc=stb=busy=0, no done pulse, cmd_ready=1 after release.
